// File: rtl/store_buffer.sv
// Purpose : posted-write store buffer between the CPU data port and a single-ported memory.
// Latency : stores retire in 1 cycle into the FIFO; a read miss returns 3+ cycles after request.
// Backpress: cpu_stall holds stores while full and reads until their data is ready.
//
// Ports
//   clk, reset                 single clock; asynchronous active-low reset
//   cpu_addr/cpu_wdata         processor address and store data
//   cpu_read/cpu_write         processor load/store requests (write wins if both)
//   cpu_rdata/cpu_stall        load data back to the processor; combinational hold request
//   mem_req/mem_we/mem_addr/mem_wdata   memory transaction, stable until mem_ack
//   mem_ack/mem_rdata          memory completion and read data
//
// Build option
//   STORE_BUF_FWD_EN : when defined, loads that hit a buffered store are answered from the
//                      youngest matching entry without a memory access. When undefined, any
//                      load waits for the buffer to drain completely and then reads memory.
module store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    input  logic        cpu_read,
    input  logic        cpu_write,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    // Stores are always full words, so only the word address is kept.
    typedef struct packed {
        logic [29:0] wordAddr;
        logic [31:0] data;
    } entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WR_BUSY = 2'd1,
        RD_BUSY = 2'd2,
        RD_DONE = 2'd3
    } state_t;

    entry_t          entries [DEPTH];
    state_t          state;
    state_t          stateNext;
    logic [PW-1:0]   head;
    logic [PW-1:0]   tail;
    logic [CW-1:0]   count;
    logic [CW-1:0]   countAfterPop;
    logic [31:0]     rdataReg;

    logic            readReq;
    logic            full;
    logic            push;
    logic            pop;
    logic            readMiss;
    logic            rdIssueIdle;
    logic            rdIssueAfterPop;
    logic [PW-1:0]   presentIdx;
    logic            loadWr;
    logic            loadRd;

    // A simultaneous read and write is treated as a write only.
    assign readReq       = cpu_read && !cpu_write;
    assign full          = (count == CW'(DEPTH));
    assign push          = cpu_write && !full;
    assign pop           = (state == WR_BUSY) && mem_ack;
    assign countAfterPop = count - CW'(1);

`ifdef STORE_BUF_FWD_EN
    logic            fwdHit;
    logic [31:0]     fwdData;
    logic [PW-1:0]   scanIdx;

    // Walk entries oldest to youngest so the last match wins: the youngest store
    // to a word is the architecturally visible one.
    always_comb begin
        fwdHit  = 1'b0;
        fwdData = '0;
        scanIdx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            scanIdx = head + PW'(i);
            if ((CW'(i) < count) && (entries[scanIdx].wordAddr == cpu_addr[31:2])) begin
                fwdHit  = 1'b1;
                fwdData = entries[scanIdx].data;
            end
        end
    end

    // A miss never matches an older store, so it may overtake the buffered writes.
    assign readMiss        = readReq && !fwdHit;
    assign rdIssueIdle     = readMiss;
    assign rdIssueAfterPop = readMiss;
    assign cpu_rdata       = (readReq && fwdHit) ? fwdData : rdataReg;
`else
    // Without matching, a load can only go to memory once every older store has
    // retired; the last pop hands the bus straight to the read.
    assign readMiss        = readReq;
    assign rdIssueIdle     = readReq && (count == '0);
    assign rdIssueAfterPop = readReq && (count == CW'(1));
    assign cpu_rdata       = rdataReg;
`endif

    // Stores stall only on a full buffer, even if an entry pops this cycle.
    // Loads stall until RD_DONE, where the registered data is handed over.
    always_comb begin
        cpu_stall = 1'b0;
        if (cpu_write) begin
            cpu_stall = full;
        end else if (cpu_read) begin
            cpu_stall = readMiss && (state != RD_DONE);
        end
    end

    always_comb begin
        stateNext  = state;
        presentIdx = head;
        loadWr     = 1'b0;
        loadRd     = 1'b0;
        case (state)
            IDLE: begin
                if (rdIssueIdle) begin
                    stateNext = RD_BUSY;
                    loadRd    = 1'b1;
                end else if (count != '0) begin
                    stateNext = WR_BUSY;
                    loadWr    = 1'b1;
                end
            end
            WR_BUSY: begin
                if (mem_ack) begin
                    // The head pops on this edge, so the next write is head+1.
                    presentIdx = head + PW'(1);
                    if (rdIssueAfterPop) begin
                        stateNext = RD_BUSY;
                        loadRd    = 1'b1;
                    end else if (countAfterPop != '0) begin
                        stateNext = WR_BUSY;
                        loadWr    = 1'b1;
                    end else begin
                        stateNext = IDLE;
                    end
                end
            end
            RD_BUSY: begin
                if (mem_ack) begin
                    stateNext = RD_DONE;
                end
            end
            RD_DONE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Control state and memory-side registers. The memory outputs are loaded only
    // on entry to a busy state, which keeps them stable until the acknowledge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdataReg  <= '0;
        end else begin
            state <= stateNext;
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            count   <= count + CW'(push) - CW'(pop);
            mem_req <= (stateNext == WR_BUSY) || (stateNext == RD_BUSY);
            if (loadWr) begin
                mem_we    <= 1'b1;
                mem_addr  <= {entries[presentIdx].wordAddr, 2'b00};
                mem_wdata <= entries[presentIdx].data;
            end else if (loadRd) begin
                mem_we   <= 1'b0;
                mem_addr <= cpu_addr;
            end
            if ((state == RD_BUSY) && mem_ack) begin
                rdataReg <= mem_rdata;
            end
        end
    end

    // Entry payload needs no reset: count==0 marks every slot invalid.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail] <= '{wordAddr: cpu_addr[31:2], data: cpu_wdata};
        end
    end

endmodule

// File: tb/tb_store_buffer.sv
// Purpose : directed scoreboard bench for store_buffer (fill/stall, read miss, ordering, reset).
// Latency : memory responder acks ackDelay cycles after a request appears.
// Backpress: CPU requests are held until cpu_stall is sampled low.
module tb_store_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack   = 1'b0;
    logic [31:0] mem_rdata = 32'h0;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_read  (cpu_read),
        .cpu_write (cpu_write),
        .cpu_rdata (cpu_rdata),
        .cpu_stall (cpu_stall),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } memTxn_t;

    memTxn_t     sbq[$];
    int          total     = 0;
    int          bad       = 0;
    logic        ackEn     = 1'b0;
    int          ackDelay  = 0;
    int          reqAge    = 0;
    int          memWrites = 0;
    logic [31:0] rdVal     = 32'h0;

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic expectMem(input logic we, input logic [31:0] addr, input logic [31:0] data);
        memTxn_t t;
        t.we   = we;
        t.addr = addr;
        t.data = data;
        sbq.push_back(t);
    endtask

    // Memory model: acks each transaction once it has been up for ackDelay cycles,
    // and checks every completed transaction against the expected-order queue.
    always @(negedge clk) begin
        memTxn_t obsT;
        memTxn_t expT;
        mem_ack = ackEn && mem_req && (reqAge >= ackDelay);
        if (mem_req && mem_ack) begin
            obsT.we   = mem_we;
            obsT.addr = mem_addr;
            obsT.data = mem_we ? mem_wdata : 32'h0;
            if (sbq.size() > 0) expT = sbq.pop_front();
            else                expT = '1;
            check("mem_txn", {7'b0, obsT}, {7'b0, expT});
            if (!mem_we) mem_rdata = rdVal;
            if (mem_we)  memWrites++;
            reqAge = 0;
        end else if (mem_req) begin
            reqAge++;
        end else begin
            reqAge = 0;
        end
    end

    // All steps start and end just after a rising edge.
    task automatic sync;
        @(posedge clk);
        #1;
    endtask

    task automatic doStore(input logic [31:0] a, input logic [31:0] d, output int stalls);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_write = 1'b1;
        stalls    = 0;
        @(negedge clk);
        while (cpu_stall && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        if (stalls >= 100) check("store_timeout", 72'(stalls), 72'(0));
        sync();
        cpu_write = 1'b0;
    endtask

    task automatic doLoad(input logic [31:0] a, output int stalls, output logic [31:0] data,
                          output logic reqAtAccept);
        cpu_addr = a;
        cpu_read = 1'b1;
        stalls   = 0;
        @(negedge clk);
        while (cpu_stall && stalls < 100) begin
            stalls++;
            @(negedge clk);
        end
        if (stalls >= 100) check("load_timeout", 72'(stalls), 72'(0));
        data        = cpu_rdata;
        reqAtAccept = mem_req;
        sync();
        cpu_read = 1'b0;
    endtask

    task automatic waitDrain(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(sbq.size() == 0 && !mem_req) && n < 300);
        check(tag, 72'(n < 300), 72'(1));
        sync();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int          s;
        int          w0;
        logic [31:0] d;
        logic        r;

        reset = 1'b0; cpu_addr = '0; cpu_wdata = '0; cpu_read = 1'b0; cpu_write = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_req",   72'(mem_req),   72'(0));
        check("rst_mem_we",    72'(mem_we),    72'(0));
        check("rst_mem_addr",  72'(mem_addr),  72'(0));
        check("rst_mem_wdata", 72'(mem_wdata), 72'(0));
        check("rst_cpu_rdata", 72'(cpu_rdata), 72'(0));
        check("rst_cpu_stall", 72'(cpu_stall), 72'(0));
        sync();
        reset = 1'b1;
        @(negedge clk);
        check("idle_stall", 72'(cpu_stall), 72'(0));
        check("idle_req",   72'(mem_req),   72'(0));
        sync();

        // Fill the buffer with memory frozen, then a fifth store must wait for a pop.
        ackEn = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            expectMem(1'b1, 32'h10 + 32'(4 * i), 32'h1000_0000 + 32'(i));
            doStore(32'h10 + 32'(4 * i), 32'h1000_0000 + 32'(i), s);
            check($sformatf("fill_stall%0d", i), 72'(s), 72'(0));
        end
        @(negedge clk);
        check("fill_req",  72'(mem_req),  72'(1));
        check("fill_we",   72'(mem_we),   72'(1));
        check("fill_addr", 72'(mem_addr), 72'(32'h10));
        sync();
        expectMem(1'b1, 32'h20, 32'h1000_0004);
        cpu_addr = 32'h20; cpu_wdata = 32'h1000_0004; cpu_write = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("full_stall", 72'(cpu_stall), 72'(1));
        end
        sync();
        ackEn = 1'b1; ackDelay = 0;
        @(negedge clk);
        check("full_stall_on_pop", 72'(cpu_stall), 72'(1));
        @(negedge clk);
        check("full_stall_release", 72'(cpu_stall), 72'(0));
        sync();
        cpu_write = 1'b0;
        waitDrain("drain_fill");

        // Read miss on an empty buffer, memory acks one cycle after the request.
        ackEn = 1'b1; ackDelay = 1; rdVal = 32'h1234_5678;
        expectMem(1'b0, 32'h80, 32'h0);
        doLoad(32'h80, s, d, r);
        check("miss_stall", 72'(s), 72'(3));
        check("miss_data",  72'(d), 72'(32'h1234_5678));
        check("rd_done_req", 72'(r), 72'(0));
        waitDrain("drain_miss");
        repeat (3) @(negedge clk);
        check("rdata_hold", 72'(cpu_rdata), 72'(32'h1234_5678));
        sync();

        // Two buffered stores, first already on the bus, then a load miss to 0x200.
        ackEn = 1'b0; rdVal = 32'hCAFE_F00D;
`ifdef STORE_BUF_FWD_EN
        expectMem(1'b1, 32'h100, 32'hA1A1_A1A1);
        expectMem(1'b0, 32'h200, 32'h0);
        expectMem(1'b1, 32'h104, 32'hB2B2_B2B2);
`else
        expectMem(1'b1, 32'h100, 32'hA1A1_A1A1);
        expectMem(1'b1, 32'h104, 32'hB2B2_B2B2);
        expectMem(1'b0, 32'h200, 32'h0);
`endif
        doStore(32'h100, 32'hA1A1_A1A1, s);
        check("ord_st0_stall", 72'(s), 72'(0));
        doStore(32'h104, 32'hB2B2_B2B2, s);
        check("ord_st1_stall", 72'(s), 72'(0));
        @(negedge clk);
        check("ord_wr_busy_we",   72'(mem_we),   72'(1));
        check("ord_wr_busy_addr", 72'(mem_addr), 72'(32'h100));
        sync();
        ackEn = 1'b1; ackDelay = 1;
        doLoad(32'h200, s, d, r);
        check("ord_data", 72'(d), 72'(32'hCAFE_F00D));
        waitDrain("drain_order");

`ifdef STORE_BUF_FWD_EN
        // Load hitting two stores to the same word returns the younger one at once.
        ackEn = 1'b0;
        expectMem(1'b1, 32'h40, 32'hAAAA_0000);
        expectMem(1'b1, 32'h40, 32'hBBBB_0000);
        doStore(32'h40, 32'hAAAA_0000, s);
        doStore(32'h40, 32'hBBBB_0000, s);
        doLoad(32'h40, s, d, r);
        check("fwd_stall", 72'(s), 72'(0));
        check("fwd_data",  72'(d), 72'(32'hBBBB_0000));
        ackEn = 1'b1; ackDelay = 0;
        waitDrain("drain_fwd");
`else
        // Load to a buffered word waits for the write to retire, then reads memory.
        ackEn = 1'b1; ackDelay = 1; rdVal = 32'h5555_AAAA;
        expectMem(1'b1, 32'h40, 32'h0BAD_F00D);
        expectMem(1'b0, 32'h40, 32'h0);
        doStore(32'h40, 32'h0BAD_F00D, s);
        doLoad(32'h40, s, d, r);
        check("nofwd_stall", 72'(s), 72'(5));
        check("nofwd_data",  72'(d), 72'(32'h5555_AAAA));
        waitDrain("drain_nofwd");
`endif

        // Reset mid-write with three stores buffered: nothing more may reach memory.
        ackEn = 1'b0;
        doStore(32'h300, 32'h3000_0000, s);
        doStore(32'h304, 32'h3000_0001, s);
        doStore(32'h308, 32'h3000_0002, s);
        @(negedge clk);
        check("rst_mid_busy", 72'(mem_req), 72'(1));
        #2;
        reset = 1'b0;
        #1;
        check("rst_async_drop", 72'(mem_req), 72'(0));
        sync();
        reset = 1'b1;
        ackEn = 1'b1; ackDelay = 0;
        w0 = memWrites;
        repeat (10) @(negedge clk);
        check("rst_no_req",    72'(mem_req),   72'(0));
        check("rst_no_writes", 72'(memWrites), 72'(w0));
        sync();
        ackEn = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            expectMem(1'b1, 32'h400 + 32'(4 * i), 32'h4000_0000 + 32'(i));
            doStore(32'h400 + 32'(4 * i), 32'h4000_0000 + 32'(i), s);
            check($sformatf("rst_refill%0d", i), 72'(s), 72'(0));
        end
        cpu_addr = 32'h500; cpu_wdata = 32'h5000_0000; cpu_write = 1'b1;
        @(negedge clk);
        check("rst_refill_full", 72'(cpu_stall), 72'(1));
        sync();
        cpu_write = 1'b0;
        ackEn = 1'b1;
        waitDrain("drain_refill");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
